clock_time_core: RTL and testbench
==================================

# clock_time_core

Timekeeping stage of `tt_um_digitalclock`, directly upstream of the display/output logic that drives `uo_out`. Divides the system clock to a one-second tick and maintains 24-hour HH:MM:SS in packed BCD. Accepts single-cycle, already-debounced set pulses for minutes and hours. Emits per-second and midnight pulses.

## Interface
- `TICK_DIV`, 10_000_000: system clock cycles per second; must be ≥ 2; prescaler width is `$clog2(TICK_DIV)`.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design-selected enable; when 0, all state holds and pulses stay 0.
- `run`  in  1  1 = prescaler counts; 0 = prescaler and time hold (set pulses still honoured).
- `inc_min`  in  1  one-cycle pulse: advance minutes by one.
- `inc_hr`  in  1  one-cycle pulse: advance hours by one.
- `hr_bcd`  out  6  hours `{tens[1:0], ones[3:0]}`, 00–23.
- `min_bcd`  out  7  minutes `{tens[2:0], ones[3:0]}`, 00–59.
- `sec_bcd`  out  7  seconds `{tens[2:0], ones[3:0]}`, 00–59.
- `sec_tick`  out  1  one-cycle pulse, high in the first cycle a new second value is visible.
- `midnight`  out  1  one-cycle pulse, high in the first cycle 00:00:00 is visible after rollover from 23:59:59.

## Operation
- Reset: prescaler = 0, time = 00:00:00, `sec_tick` = 0, `midnight` = 0. All outputs are registered.
- Active cycle: `ena` = 1. When `ena` = 0, nothing changes, including set pulses (ignored).
- Prescaler: on an active cycle with `run` = 1, counts 0 → `TICK_DIV-1` → 0. The cycle with count = `TICK_DIV-1` is the tick cycle.
- Tick cycle, no set pulse:
  - seconds += 1.
  - 59 → 00 carries into minutes; 59 → 00 carries into hours; 23 → 00 wraps.
  - Each BCD ones digit wraps 9 → 0 with carry to its tens digit.
  - Illegal codes never arise.
- `inc_min` (active cycle):
  - minutes += 1, 59 → 00 with no carry into hours.
  - seconds forced to 00; prescaler forced to 0.
- `inc_hr` (active cycle): hours += 1, 23 → 00. Seconds and minutes unchanged. Prescaler forced to 0.
- Both pulses in the same cycle: both apply. Seconds = 00, prescaler = 0.
- Any set pulse in a tick cycle: the tick is suppressed (no seconds advance, no carry) and the set rules above apply.
- `sec_tick` is registered: set to 1 on the edge that applies a tick advance, cleared on the next edge. Set pulses never raise it.
- `midnight` is registered: set on the edge where a tick advance takes 23:59:59 → 00:00:00, cleared on the next edge. Wrap-around caused by `inc_hr` or `inc_min` never raises it.
- Reset mid-operation: immediate asynchronous return to reset values. Any pending tick is lost.

## Timing
- Tick period: exactly `TICK_DIV` active `run` cycles. Cycles with `ena` = 0 or `run` = 0 stretch the period; they do not reset it.
- Latency: the time value changes on the clock edge that ends the tick cycle and is visible the following cycle, with `sec_tick` = 1 in that same cycle.
- Set-pulse latency: 1 cycle. The edge ending the pulse cycle updates the time.
- After a set pulse, the next tick occurs `TICK_DIV` active run cycles later.
- No handshake; inputs are sampled every active cycle. Pulses wider than one cycle apply once per high cycle.
- First tick after reset release: `TICK_DIV` cycles after the first active run cycle.

## Test plan
Run with `TICK_DIV` = 4.
- Reset, then `ena` = `run` = 1 for 12 cycles → `sec_bcd` = 0x03; exactly three one-cycle `sec_tick` pulses, 4 cycles apart.
- Run from reset through 600 ticks → `min_bcd` = 0x10, `sec_bcd` = 0x00; no `midnight`.
- Preload via 23× `inc_hr` + 59× `inc_min`, then run 60 ticks:
  - at 00:00:00, `hr_bcd` = 0, `min_bcd` = 0;
  - `midnight` and `sec_tick` both high for exactly one cycle.
- At 00:59:xx, pulse `inc_min` in a tick cycle → 00:00:00 (no hour carry, no `sec_tick`); next tick arrives 4 cycles later.
- From 23:00:05, pulse `inc_hr` → 00:00:05 with `midnight` = 0. Then pulse `inc_hr` + `inc_min` together → 01:01:00.
- Mid-count:
  - drop `ena` for 5 cycles → no change, pulses ignored, tick delayed by 5 cycles.
  - assert `rst_n` = 0 asynchronously between edges → outputs read 00:00:00 before the next edge.

Source files
------------

// File: rtl/clock_time_core_if.sv
// Control inputs and BCD time outputs of the timekeeping core.
// The master drives enables and set pulses; the slave (core) drives time and pulses.
interface clock_time_core_if;
    logic       ena;
    logic       run;
    logic       inc_min;
    logic       inc_hr;
    logic [5:0] hr_bcd;
    logic [6:0] min_bcd;
    logic [6:0] sec_bcd;
    logic       sec_tick;
    logic       midnight;

    modport master (
        output ena,
        output run,
        output inc_min,
        output inc_hr,
        input  hr_bcd,
        input  min_bcd,
        input  sec_bcd,
        input  sec_tick,
        input  midnight
    );

    modport slave (
        input  ena,
        input  run,
        input  inc_min,
        input  inc_hr,
        output hr_bcd,
        output min_bcd,
        output sec_bcd,
        output sec_tick,
        output midnight
    );
endinterface

// File: rtl/clock_time_core.sv
// One-second prescaler and 24-hour BCD HH:MM:SS counter with minute/hour set pulses.
// Emits registered one-cycle sec_tick and midnight pulses.
module clock_time_core #(
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    clock_time_core_if.slave   bus
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      hr_q, hr_d;
    logic [6:0]      min_q, min_d;
    logic [6:0]      sec_q, sec_d;
    logic            sec_tick_q, sec_tick_d;
    logic            midnight_q, midnight_d;

    logic set_pulse;
    logic tick;
    logic sec_wrap;
    logic min_wrap;
    logic hr_wrap;

    // Modulo-60 BCD increment: {tens[2:0], ones[3:0]}.
    function automatic logic [6:0] inc_bcd60(input logic [6:0] v);
        logic [6:0] r;
        if (v[3:0] == 4'd9) begin
            r = (v[6:4] == 3'd5) ? 7'h00 : {v[6:4] + 3'd1, 4'd0};
        end else begin
            r = {v[6:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Modulo-24 BCD increment: {tens[1:0], ones[3:0]}.
    function automatic logic [5:0] inc_bcd24(input logic [5:0] v);
        logic [5:0] r;
        if (v == 6'h23) begin
            r = 6'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[5:4] + 2'd1, 4'd0};
        end else begin
            r = {v[5:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign set_pulse = bus.inc_min | bus.inc_hr;
    // A set pulse in the tick cycle swallows the tick.
    assign tick      = bus.ena & bus.run & (cnt_q == CntMax) & ~set_pulse;
    assign sec_wrap  = (sec_q == 7'h59);
    assign min_wrap  = (min_q == 7'h59);
    assign hr_wrap   = (hr_q == 6'h23);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.ena) begin
            if (set_pulse) begin
                cnt_d = '0;
            end else if (bus.run) begin
                cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
            end
        end
    end

    always_comb begin
        hr_d  = hr_q;
        min_d = min_q;
        sec_d = sec_q;
        if (bus.ena) begin
            if (bus.inc_min) begin
                min_d = inc_bcd60(min_q);
                sec_d = 7'h00;
            end
            if (bus.inc_hr) begin
                hr_d = inc_bcd24(hr_q);
            end
            if (tick) begin
                sec_d = inc_bcd60(sec_q);
                if (sec_wrap) begin
                    min_d = inc_bcd60(min_q);
                    if (min_wrap) begin
                        hr_d = inc_bcd24(hr_q);
                    end
                end
            end
        end
    end

    always_comb begin
        sec_tick_d = tick;
        midnight_d = tick & sec_wrap & min_wrap & hr_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            hr_q       <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            sec_tick_q <= 1'b0;
            midnight_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hr_q       <= hr_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            sec_tick_q <= sec_tick_d;
            midnight_q <= midnight_d;
        end
    end

    assign bus.hr_bcd   = hr_q;
    assign bus.min_bcd  = min_q;
    assign bus.sec_bcd  = sec_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.midnight = midnight_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Scoreboard bench for clock_time_core: a seconds-of-day model predicts every cycle,
// a monitor compares the DUT against the queued predictions.
module tb_clock_time_core;

    localparam int unsigned TickDiv = 4;

    logic clk;
    logic rst_n;

    clock_time_core_if bus ();

    clock_time_core #(
        .TICK_DIV (TickDiv)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int compared;
    int mismatched;
    int n_tick;
    int n_mid;

    // Reference state: time as seconds since midnight, prescaler as plain count.
    int tod;
    int presc;

    logic [21:0] exp_q[$];

    function automatic logic [6:0] bcd7(input int n);
        return {3'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [5:0] bcd6(input int n);
        return {2'(n / 10), 4'(n % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        tod   = 0;
        presc = 0;
    endtask

    // Drive one cycle of stimulus, advance the model and queue the expected outputs.
    task automatic step(input logic e, input logic r, input logic im, input logic ih);
        int  h, m, s;
        logic tk, md;
        @(negedge clk);
        bus.ena     = e;
        bus.run     = r;
        bus.inc_min = im;
        bus.inc_hr  = ih;
        tk = 1'b0;
        md = 1'b0;
        if (e) begin
            if (im || ih) begin
                h = tod / 3600;
                m = (tod / 60) % 60;
                s = tod % 60;
                if (im) begin
                    m = (m + 1) % 60;
                    s = 0;
                end
                if (ih) h = (h + 1) % 24;
                tod   = h * 3600 + m * 60 + s;
                presc = 0;
            end else if (r) begin
                if (presc == TickDiv - 1) begin
                    presc = 0;
                    tod   = (tod + 1) % 86400;
                    tk    = 1'b1;
                    md    = (tod == 0);
                end else begin
                    presc++;
                end
            end
        end
        exp_q.push_back({bcd6(tod / 3600), bcd7((tod / 60) % 60), bcd7(tod % 60), tk, md});
        @(posedge clk);
        #2;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.ena     = 1'b0;
        bus.run     = 1'b0;
        bus.inc_min = 1'b0;
        bus.inc_hr  = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle with a pending prediction is compared in full.
    always @(posedge clk) begin
        logic [21:0] e;
        logic [21:0] a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.hr_bcd, bus.min_bcd, bus.sec_bcd, bus.sec_tick, bus.midnight};
            check("cycle_state", 32'(a), 32'(e));
            if (bus.sec_tick) n_tick++;
            if (bus.midnight) n_mid++;
        end
    end

    initial begin
        logic [19:0] saved;
        int          t0;
        compared   = 0;
        mismatched = 0;
        n_tick     = 0;
        n_mid      = 0;
        exp_q      = {};
        bus.ena     = 1'b0;
        bus.run     = 1'b0;
        bus.inc_min = 1'b0;
        bus.inc_hr  = 1'b0;
        rst_n       = 1'b1;
        #1;
        do_reset();
        #1;
        check("reset_state",
              32'({bus.hr_bcd, bus.min_bcd, bus.sec_bcd, bus.sec_tick, bus.midnight}), 32'd0);

        // Twelve active cycles give three ticks.
        n_tick = 0;
        run_cycles(12);
        check("sec_after_12", 32'(bus.sec_bcd), 32'h03);
        check("ticks_in_12", 32'(n_tick), 32'd3);

        // 600 seconds from reset.
        do_reset();
        n_mid = 0;
        run_cycles(600 * TickDiv);
        check("min_after_600s", 32'(bus.min_bcd), 32'h10);
        check("sec_after_600s", 32'(bus.sec_bcd), 32'h00);
        check("no_midnight_600s", 32'(n_mid), 32'd0);

        // Preload 23:59:00 and roll over at midnight.
        do_reset();
        for (int i = 0; i < 23; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 59; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("preload", 32'({bus.hr_bcd, bus.min_bcd, bus.sec_bcd}), 32'({6'h23, 7'h59, 7'h00}));
        n_mid = 0;
        run_cycles(60 * TickDiv);
        check("midnight_time", 32'({bus.hr_bcd, bus.min_bcd, bus.sec_bcd}), 32'd0);
        check("midnight_once", 32'(n_mid), 32'd1);

        // inc_min in a tick cycle at 00:59:02: no hour carry, no tick.
        for (int i = 0; i < 59; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        run_cycles(2 * TickDiv + 3);
        t0 = n_tick;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("inc_min_wrap", 32'({bus.hr_bcd, bus.min_bcd, bus.sec_bcd}), 32'd0);
        check("inc_min_no_tick", 32'(n_tick - t0), 32'd0);
        run_cycles(TickDiv - 1);
        check("tick_not_early", 32'(n_tick - t0), 32'd0);
        run_cycles(1);
        check("tick_after_set", 32'(n_tick - t0), 32'd1);

        // From 23:00:05, inc_hr wraps without midnight; then both pulses together.
        do_reset();
        for (int i = 0; i < 23; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        run_cycles(5 * TickDiv);
        n_mid = 0;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("inc_hr_wrap", 32'({bus.hr_bcd, bus.min_bcd, bus.sec_bcd}), 32'({6'h00, 7'h00, 7'h05}));
        check("inc_hr_no_mid", 32'(n_mid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("both_pulses", 32'({bus.hr_bcd, bus.min_bcd, bus.sec_bcd}), 32'({6'h01, 7'h01, 7'h00}));

        // ena low mid-count: state holds and set pulses are ignored.
        run_cycles(2);
        saved = {bus.hr_bcd, bus.min_bcd, bus.sec_bcd};
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i[0], ~i[0]);
        check("ena_hold", 32'({bus.hr_bcd, bus.min_bcd, bus.sec_bcd}), 32'(saved));
        t0 = n_tick;
        run_cycles(1);
        check("ena_delays_tick", 32'(n_tick - t0), 32'd0);
        run_cycles(1);
        check("ena_tick_arrives", 32'(n_tick - t0), 32'd1);

        // Asynchronous reset between edges.
        run_cycles(TickDiv * 3 + 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset",
              32'({bus.hr_bcd, bus.min_bcd, bus.sec_bcd, bus.sec_tick, bus.midnight}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic, seeded into mid-day with set pulses first.
        for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom_range(0, 1)),
                                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0));
        end

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
